// File: rtl/sr_cmd_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sr_cmd_sequencer_pkg                                      |
// | Purpose  : Shared FSM state encoding and default parameter values    |
// |            for the SR command sequencer and its input debouncers.    |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
`ifndef SR_CMD_SEQUENCER_PKG_SV
`define SR_CMD_SEQUENCER_PKG_SV

package sr_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE_S = 2'd1,
        ST_PULSE_R = 2'd2,
        ST_GAP     = 2'd3
    } state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES    = 4;
    localparam int unsigned DEF_PULSE_WIDTH        = 2;
    localparam int unsigned DEF_RESET_PRIORITY     = 1;
    localparam int unsigned DEF_SUPPRESS_REDUNDANT = 1;

endpackage

`endif
`default_nettype wire

// File: rtl/sr_cmd_sequencer_debounce_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sr_debounce_sync                                          |
// | Purpose  : 2-flop synchronizer, debounce counter, stable level and   |
// |            one-cycle rising-edge pulse for one raw request line.     |
// | Ports    : clock  - system clock                                     |
// |            reset  - asynchronous active-high reset                   |
// |            raw_i  - raw asynchronous, bouncy input                   |
// |            rise_o - one-cycle pulse when the stable level goes 0->1  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sr_debounce_sync
    import sr_cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o
);

    localparam int unsigned            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter value seen on the edge that completes the hold period.
    localparam logic [CW-1:0]          CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          armed_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            armed_q  <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (!armed_q) begin
                // After reset the line must be seen released for a full
                // debounce period before presses count, so a button held
                // through reset does not produce a fresh command.
                if (sync2_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    armed_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else if (sync2_q != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_q <= sync2_q;
                    rise_q   <= sync2_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/sr_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sr_cmd_sequencer                                          |
// | Purpose  : Turns raw set/reset requests into clean, mutually         |
// |            exclusive S/R pulses for a gated SR flip-flop and keeps a |
// |            shadow copy of the expected Q.                            |
// | Ports    : clock, reset (async, active-high)                         |
// |            set_btn, reset_btn - raw asynchronous requests            |
// |            S, R      - registered command pulses                     |
// |            busy      - pulse or gap in progress                      |
// |            conflict  - both requests pending in one IDLE cycle       |
// |            q_state   - shadow of the flip-flop Q                     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sr_cmd_sequencer
    import sr_cmd_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PULSE_WIDTH        = DEF_PULSE_WIDTH,
    parameter int unsigned RESET_PRIORITY     = DEF_RESET_PRIORITY,
    parameter int unsigned SUPPRESS_REDUNDANT = DEF_SUPPRESS_REDUNDANT
) (
    input  logic clock,
    input  logic reset,
    input  logic set_btn,
    input  logic reset_btn,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict,
    output logic q_state
);

    localparam int unsigned     PW_W    = $clog2(PULSE_WIDTH + 1);
    localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_WIDTH);
    localparam logic            C_RPRI  = (RESET_PRIORITY != 0);
    localparam logic            C_SUPP  = (SUPPRESS_REDUNDANT != 0);

    logic            w_set_rise;
    logic            w_rst_rise;
    logic            w_req_s;
    logic            w_req_r;
    logic            w_win_s;
    logic            w_win_r;
    logic            w_go_s;
    logic            w_go_r;

    state_e          state_q;
    logic [PW_W-1:0] pcnt_q;
    logic            pend_s_q;
    logic            pend_r_q;
    logic            s_q;
    logic            r_q;
    logic            busy_q;
    logic            conflict_q;
    logic            qstate_q;

    sr_debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clock  (clock),
        .reset  (reset),
        .raw_i  (set_btn),
        .rise_o (w_set_rise)
    );

    sr_debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
        .clock  (clock),
        .reset  (reset),
        .raw_i  (reset_btn),
        .rise_o (w_rst_rise)
    );

    // A rise in the same cycle counts as pending, so an accepted edge is
    // served on the very next clock without an extra flag stage.
    assign w_req_s = pend_s_q | w_set_rise;
    assign w_req_r = pend_r_q | w_rst_rise;

    // Arbitration first, then suppression of a winner that would not
    // change Q. The loser of a conflict is dropped either way.
    assign w_win_s = w_req_s & (~w_req_r | ~C_RPRI);
    assign w_win_r = w_req_r & (~w_req_s |  C_RPRI);
    assign w_go_s  = w_win_s & ~(C_SUPP &  qstate_q);
    assign w_go_r  = w_win_r & ~(C_SUPP & ~qstate_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= '0;
            pend_s_q   <= 1'b0;
            pend_r_q   <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            qstate_q   <= 1'b0;
        end else begin
            conflict_q <= 1'b0;
            // While busy, new edges merge into the pending flags.
            pend_s_q   <= pend_s_q | w_set_rise;
            pend_r_q   <= pend_r_q | w_rst_rise;
            case (state_q)
                ST_IDLE: begin
                    pend_s_q   <= 1'b0;
                    pend_r_q   <= 1'b0;
                    conflict_q <= w_req_s & w_req_r;
                    if (w_go_s) begin
                        state_q  <= ST_PULSE_S;
                        s_q      <= 1'b1;
                        busy_q   <= 1'b1;
                        qstate_q <= 1'b1;
                        pcnt_q   <= PW_W'(1);
                    end else if (w_go_r) begin
                        state_q  <= ST_PULSE_R;
                        r_q      <= 1'b1;
                        busy_q   <= 1'b1;
                        qstate_q <= 1'b0;
                        pcnt_q   <= PW_W'(1);
                    end
                end
                ST_PULSE_S, ST_PULSE_R: begin
                    if (pcnt_q == PW_LAST) begin
                        state_q <= ST_GAP;
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        pcnt_q  <= '0;
                    end else begin
                        pcnt_q <= pcnt_q + PW_W'(1);
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign q_state  = qstate_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sr_cmd_sequencer                                       |
// | Purpose  : Self-checking bench for sr_cmd_sequencer: per-cycle       |
// |            vector table plus hand-written multi-cycle sequences.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_sr_cmd_sequencer;

    logic clock = 1'b0;
    logic reset;
    logic set_btn;
    logic reset_btn;
    logic S, R, busy, conflict, q_state;
    logic S1, R1, busy1, conflict1, q1;

    always #5 clock = ~clock;

    sr_cmd_sequencer #(
        .DEBOUNCE_CYCLES(4), .PULSE_WIDTH(2),
        .RESET_PRIORITY(1), .SUPPRESS_REDUNDANT(1)
    ) dut (
        .clock(clock), .reset(reset), .set_btn(set_btn), .reset_btn(reset_btn),
        .S(S), .R(R), .busy(busy), .conflict(conflict), .q_state(q_state)
    );

    sr_cmd_sequencer #(
        .DEBOUNCE_CYCLES(4), .PULSE_WIDTH(2),
        .RESET_PRIORITY(1), .SUPPRESS_REDUNDANT(0)
    ) dut_ns (
        .clock(clock), .reset(reset), .set_btn(set_btn), .reset_btn(reset_btn),
        .S(S1), .R(R1), .busy(busy1), .conflict(conflict1), .q_state(q1)
    );

    typedef struct {
        logic       set_b;
        logic       rst_b;
        logic [4:0] exp;   // {S, R, busy, conflict, q_state}
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic r, input int n, input logic [4:0] e);
        vec_t v;
        v.set_b = s;
        v.rst_b = r;
        v.exp   = e;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    int r_cnt, s_cnt, ovl, r_first, r_last, s_first, s_last;
    int r1_cnt, busy_cnt;

    initial begin
        reset     = 1'b1;
        set_btn   = 1'b0;
        reset_btn = 1'b0;

        // Idle while the debouncers arm after reset.
        add(0, 0, 6, 5'b00000);
        // 3-cycle press is shorter than the debounce window: ignored.
        add(1, 0, 3, 5'b00000);
        add(0, 0, 8, 5'b00000);
        // Held press: S on cycles 7-8, gap on 9, Q set from 7.
        add(1, 0, 6, 5'b00000);
        add(1, 0, 2, 5'b10101);
        add(1, 0, 1, 5'b00101);
        add(1, 0, 3, 5'b00001);
        add(0, 0, 8, 5'b00001);
        // Simultaneous press with Q=1: R wins, conflict for one cycle.
        add(1, 1, 6, 5'b00001);
        add(1, 1, 1, 5'b01110);
        add(1, 1, 1, 5'b01100);
        add(1, 1, 1, 5'b00100);
        add(1, 1, 3, 5'b00000);
        add(0, 0, 8, 5'b00000);

        repeat (3) @(negedge clock);
        check("reset_state", {3'b0, S, R, busy, conflict, q_state}, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            set_btn   = tbl[i].set_b;
            reset_btn = tbl[i].rst_b;
            @(negedge clock);
            check($sformatf("vec%0d", i), {3'b0, S, R, busy, conflict, q_state},
                  {3'b0, tbl[i].exp});
        end

        // Back-to-back: reset then set accepted during the R pulse.
        set_btn = 1'b1;
        repeat (12) @(negedge clock);
        set_btn = 1'b0;
        repeat (10) @(negedge clock);
        check("t4_pre_q", {7'b0, q_state}, 8'h01);
        r_cnt = 0; s_cnt = 0; ovl = 0;
        r_first = -1; r_last = -1; s_first = -1; s_last = -1;
        reset_btn = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            if (c == 3) set_btn = 1'b1;
            @(negedge clock);
            if (R) begin r_cnt++; if (r_first < 0) r_first = c; r_last = c; end
            if (S) begin s_cnt++; if (s_first < 0) s_first = c; s_last = c; end
            if (S && R) ovl++;
        end
        check("t4_r_width", 8'(r_cnt), 8'd2);
        check("t4_r_start", 8'(r_first), 8'd7);
        check("t4_r_contig", 8'(r_last - r_first), 8'd1);
        check("t4_s_width", 8'(s_cnt), 8'd2);
        check("t4_s_contig", 8'(s_last - s_first), 8'd1);
        check("t4_overlap", 8'(ovl), 8'd0);
        check("t4_gap_ok", {7'b0, (s_first - r_last) >= 2}, 8'h01);
        check("t4_final_q", {7'b0, q_state}, 8'h01);
        set_btn = 1'b0;
        reset_btn = 1'b0;
        repeat (10) @(negedge clock);

        // Redundant reset with Q=0: suppressed vs. not suppressed.
        do_reset();
        repeat (6) @(negedge clock);
        check("t5_q_init", {6'b0, q_state, q1}, 8'h00);
        r_cnt = 0; r1_cnt = 0; busy_cnt = 0;
        reset_btn = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            if (R) r_cnt++;
            if (busy) busy_cnt++;
            if (R1) r1_cnt++;
        end
        check("t5_supp_r", 8'(r_cnt), 8'd0);
        check("t5_supp_busy", 8'(busy_cnt), 8'd0);
        check("t5_nosupp_r", 8'(r1_cnt), 8'd2);
        check("t5_nosupp_q", {7'b0, q1}, 8'h00);
        reset_btn = 1'b0;
        repeat (8) @(negedge clock);

        // Reset during the first S-pulse cycle, button still held after.
        do_reset();
        repeat (6) @(negedge clock);
        set_btn = 1'b1;
        repeat (7) @(negedge clock);
        check("t6_s_started", {5'b0, S, busy, q_state}, 8'h07);
        reset = 1'b1;
        #1;
        check("t6_async_drop", {5'b0, S, busy, q_state}, 8'h00);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        s_cnt = 0; busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (S) s_cnt++;
            if (busy) busy_cnt++;
        end
        check("t6_no_new_s", 8'(s_cnt), 8'd0);
        check("t6_no_busy", 8'(busy_cnt), 8'd0);
        set_btn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
